// File: rtl/imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader: writable instruction RAM filled by a checksummed byte-serial
// frame; it holds the core in reset until a load completes.  Revision 1.0
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] a,
  output logic [31:0]   rd,
  output logic          cpu_reset,
  output logic          loaded,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [8:0] c_depth = 9'(DEPTH);

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] nlast_q, nlast_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   hold_q, hold_d;
  logic [7:0]    sum_q, sum_d;
  logic          in_ready_q, in_ready_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          loaded_q, loaded_d;
  logic          err_q, err_d;

  logic          w_accept;
  logic          w_we;
  logic [31:0]   w_wdata;

  // in_ready_q is high exactly in HDR/DATA/CSUM, so it also gates acceptance.
  assign w_accept = in_valid && in_ready_q;
  assign w_wdata  = {hold_q, in_data};

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    nlast_d = nlast_q;
    bcnt_d  = bcnt_q;
    hold_d  = hold_q;
    sum_d   = sum_q;
    w_we    = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          waddr_d = '0;
          bcnt_d  = 2'd0;
          sum_d   = 8'd0;
        end
      end
      S_HDR: begin
        if (w_accept) begin
          sum_d   = in_data;
          nlast_d = AW'(in_data - 8'd1);
          if (in_data != 8'd0 && {1'b0, in_data} <= c_depth) begin
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          sum_d  = sum_q + in_data;
          hold_d = {hold_q[15:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            w_we    = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if (waddr_q == nlast_q) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          state_d = (in_data == sum_q) ? S_RUN : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered.
    in_ready_d  = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    cpu_reset_d = (state_d != S_RUN);
    loaded_d    = (state_d == S_RUN);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      nlast_q     <= '0;
      bcnt_q      <= 2'd0;
      hold_q      <= 24'd0;
      sum_q       <= 8'd0;
      in_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      nlast_q     <= nlast_d;
      bcnt_q      <= bcnt_d;
      hold_q      <= hold_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      loaded_q    <= loaded_d;
      err_q       <= err_d;
    end
  end

  // The RAM is deliberately outside reset so a reload or reset keeps old words.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[waddr_q] <= w_wdata;
    end
  end

  assign rd        = mem[a];
  assign in_ready  = in_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign loaded    = loaded_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: table-driven directed vectors plus hand-written sequences
// for bubbles, asynchronous reset mid-load and reload from RUN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  a = 6'd0;
  logic [31:0] rd;
  logic        cpu_reset;
  logic        loaded;
  logic        err;

  int checks = 0;
  int errors = 0;

  imem_loader #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .rd(rd),
    .cpu_reset(cpu_reset), .loaded(loaded), .err(err)
  );

  always #5 clk = ~clk;

  // Expected {in_ready, cpu_reset, loaded, err}
  localparam logic [3:0] O_IDLE = 4'b0100;
  localparam logic [3:0] O_LD   = 4'b1100;
  localparam logic [3:0] O_RUN  = 4'b0010;
  localparam logic [3:0] O_ERR  = 4'b0101;

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  din;
    logic [5:0]  addr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_o;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic vld, logic [7:0] din, logic [5:0] addr,
                              logic chk_rd, logic [31:0] exp_rd, logic [3:0] exp_o);
    vec_t v;
    v.st = st; v.vld = vld; v.din = din; v.addr = addr;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_o = exp_o;
    return v;
  endfunction

  task automatic chk_o(input string name, input logic [3:0] exp_o);
    logic [3:0] act;
    act = {in_ready, cpu_reset, loaded, err};
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("FAIL %s: {in_ready,cpu_reset,loaded,err} got %b expected %b at %0t", name, act, exp_o, $time);
    end
  endtask

  task automatic chk_rd(input string name, input logic [5:0] addr, input logic [31:0] exp_rd);
    a = addr;
    #0;
    checks++;
    if (rd !== exp_rd) begin
      errors++;
      $display("FAIL %s: rd[%0d] got %h expected %h at %0t", name, addr, rd, exp_rd, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic st, input logic vld, input logic [7:0] din);
    @(negedge clk);
    start = st; in_valid = vld; in_data = din;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic add_frame2(input logic [7:0] csum);
    logic [7:0] bytes [9];
    bytes = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, O_LD));
    for (int i = 0; i < 9; i++) begin
      if (i == 4)      vecs.push_back(mk(0, 1, bytes[i], 0, 1, 32'h12345678, O_LD));
      else if (i == 8) vecs.push_back(mk(0, 1, bytes[i], 1, 1, 32'h9ABCDEF0, O_LD));
      else             vecs.push_back(mk(0, 1, bytes[i], 0, 0, 0, O_LD));
    end
    vecs.push_back(mk(0, 1, csum, 0, 1, 32'h12345678,
                      (csum == 8'h3A) ? O_RUN : O_ERR));
  endtask

  initial begin
    logic [7:0] frame [10];
    frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h3A};

    // Good load, then a byte offered in RUN must be ignored
    add_frame2(8'h3A);
    vecs.push_back(mk(0, 1, 8'h55, 1, 1, 32'h9ABCDEF0, O_RUN));
    // Bad checksum: both words still readable
    add_frame2(8'h3B);
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 32'h9ABCDEF0, O_ERR));
    // Bad headers 0x00 and 0x41
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, O_LD));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, O_ERR));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, O_LD));
    vecs.push_back(mk(0, 1, 8'h41, 0, 0, 0, O_ERR));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, O_ERR));
    // Recovery with start pulses during DATA that must be ignored
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, O_LD));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, O_LD));
    vecs.push_back(mk(1, 1, 8'h12, 0, 0, 0, O_LD));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, O_LD));
    for (int i = 2; i < 9; i++) vecs.push_back(mk(0, 1, frame[i], 0, 0, 0, O_LD));
    vecs.push_back(mk(0, 1, 8'h3A, 0, 1, 32'h12345678, O_RUN));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_o("reset_state", O_IDLE);
    @(negedge clk);
    reset = 1'b0;
    step(0, 1, 8'h02);
    chk_o("idle_ignores_valid", O_IDLE);

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].vld, vecs[i].din);
      chk_o($sformatf("vec%0d", i), vecs[i].exp_o);
      if (vecs[i].chk_rd) chk_rd($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
    end

    // Reset mid-load after 6 data bytes: word 0 updated, word 1 untouched
    step(1, 0, 8'h00);
    step(0, 1, 8'h02);
    step(0, 1, 8'h11); step(0, 1, 8'h22); step(0, 1, 8'h33); step(0, 1, 8'h44);
    step(0, 1, 8'h55); step(0, 1, 8'h66);
    chk_o("before_async_reset", O_LD);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_o("async_reset_immediate", O_IDLE);
    chk_rd("rst_word0", 0, 32'h11223344);
    chk_rd("rst_word1", 1, 32'h9ABCDEF0);
    @(negedge clk);
    reset = 1'b0;

    // Good frame with 1-3 cycle bubbles between bytes
    step(1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 3)) step(0, 0, 8'hFF);
      chk_o($sformatf("bubble_stall%0d", i), O_LD);
      step(0, 1, frame[i]);
    end
    chk_o("bubble_run", O_RUN);
    chk_rd("bubble_word0", 0, 32'h12345678);
    chk_rd("bubble_word1", 1, 32'h9ABCDEF0);

    // Reload from RUN with N=1
    step(1, 0, 8'h00);
    chk_o("reload_start", O_LD);
    step(0, 1, 8'h01); step(0, 1, 8'hAA); step(0, 1, 8'hBB); step(0, 1, 8'hCC);
    chk_o("reload_mid", O_LD);
    step(0, 1, 8'hDD);
    chk_o("reload_csum_wait", O_LD);
    chk_rd("reload_word0_early", 0, 32'hAABBCCDD);
    step(0, 1, 8'h0F);
    chk_o("reload_run", O_RUN);
    chk_rd("reload_word0", 0, 32'hAABBCCDD);
    chk_rd("reload_word1", 1, 32'h9ABCDEF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory for the single-cycle MIPS core. Byte-serial program load fills a DEPTH×32 instruction RAM, checksums the load and holds the core in reset until the load succeeds. The core reads instructions through the same combinational word-addressed port as the fixed instruction ROM it replaces in `top`. The CPU side reads the RAM; this block writes it.

## Interface
- `DEPTH`, 64: number of 32-bit instruction words.
- `AW`, 6: word-address width, log2(DEPTH).
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin a load; single-cycle pulse; sampled only in IDLE, RUN, ERR.
- `in_data`  in  8: load byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: block accepts a byte. A byte transfers on a rising edge with `in_valid && in_ready`.
- `a`  in  AW: CPU word address (`pc[7:2]`).
- `rd`  out  32: instruction word, combinational `RAM[a]`.
- `cpu_reset`  out  1: drives the core's `reset`.
- `loaded`  out  1: a load has completed with a good checksum.
- `err`  out  1: the last load failed.

## Operation
- Load frame, in order:
  - Header byte N = word count; valid range 1..DEPTH.
  - 4·N data bytes, big-endian per word (first byte → bits 31:24).
  - One checksum byte = (N + all data bytes) mod 256.
- States:
  - IDLE: `cpu_reset`=1, `in_ready`=0. `start` → HDR.
  - HDR: `in_ready`=1. Header accepted: N in 1..DEPTH → DATA; otherwise → ERR.
  - DATA: `in_ready`=1. A 2-bit byte counter assembles bytes into a 24-bit holding register. On acceptance of the 4th byte, `RAM[waddr] <= {hold, in_data}` on that same edge, then `waddr` increments. After word N-1 is written → CSUM.
  - CSUM: `in_ready`=1. Checksum byte accepted: match → RUN; mismatch → ERR.
  - RUN: `cpu_reset`=0, `loaded`=1. `start` → HDR (reload).
  - ERR: `cpu_reset`=1, `err`=1. `start` → HDR.
- Entering HDR clears `waddr`, the byte counter, the running sum, `err` and `loaded`. It also sets `cpu_reset`=1.
- Words at addresses ≥ N keep their previous contents. RAM is not cleared by `reset` or by a reload. Words written before a checksum failure stay written.
- Arithmetic:
  - Running sum is 8 bits, wraps mod 256.
  - `waddr` is AW bits. It never wraps, because N ≤ DEPTH.
  - N is compared as an 8-bit unsigned value.
- `start` in HDR, DATA or CSUM is ignored.
- `in_valid` outside HDR/DATA/CSUM is ignored and no byte is consumed.

## Timing
- Reset values: state=IDLE, `cpu_reset`=1, `in_ready`=0, `loaded`=0, `err`=0, `waddr`=0, counters 0. `rd` continues to reflect the RAM.
- All state outputs are registered and decoded from state; they change one cycle after the causing edge.
- `start` at edge k → `in_ready`=1 from cycle k+1. The first byte can be accepted at edge k+1.
- A full-rate frame (`in_valid` held high) takes 4N+2 accept edges. Bubbles in `in_valid` stall with no state change.
- Word write latency: the word is readable on `rd` in the cycle after the edge that accepts its 4th byte.
- Good checksum accepted at edge m → `cpu_reset`=0 and `loaded`=1 from cycle m+1. The core fetches address 0 at the first edge after that.
- `start` in RUN at edge r → `cpu_reset`=1 from cycle r+1.
- Asynchronous `reset` mid-load forces IDLE immediately. A partially assembled word is discarded; previously written words remain.

## Test plan
- Good load: `start`; stream 02 12 34 56 78 9A BC DE F0 3A → `rd`=0x12345678 at `a`=0 and 0x9ABCDEF0 at `a`=1. `cpu_reset` falls and `loaded`=1 one cycle after the 3A byte is accepted.
- Bad checksum: same stream ending 3B → `err`=1, `cpu_reset` stays 1, `loaded`=0. Both words are still readable.
- Bad header: header 00, then header 0x41 with `DEPTH`=64 → ERR one cycle after header acceptance; `in_ready`=0. Afterwards `start` + a good frame → RUN, `err`=0.
- Backpressure/bubbles: good frame with `in_valid` low for 1–3 random cycles between bytes → same RAM contents and checksum result as the good-load case.
- Reset mid-load: assert `reset` after 6 data bytes of an N=2 frame → IDLE immediately, `cpu_reset`=1. Word 0 is updated, word 1 is unchanged, and `loaded`=0.
- Reload from RUN: after a good load, `start` then N=1 frame AA BB CC DD with checksum (01+AA+BB+CC+DD) mod 256 = 0x0F → `cpu_reset`=1 during the load. Then `rd`[0]=0xAABBCCDD while word 1 keeps 0x9ABCDEF0.
